// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W -> 2^SEL_W one-hot decoder with DIRECT / LATCH / SWEEP / OFF modes.
// Define DEC_ACTIVE_LOW_EN to drive dec_o active-low (valid_o / wrap_o unaffected).
module onehot_decoder_seq #(
    parameter int SEL_W     = 3,
    parameter int SWEEP_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [1:0]              mode_i,
    input  logic                    load_i,
    output logic [(1<<SEL_W)-1:0]   dec_o,
    output logic                    valid_o,
    output logic                    wrap_o
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SWEEP_DIV - 1);

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] DEC_IDLE = '1;
`else
    localparam logic [OUT_W-1:0] DEC_IDLE = '0;
`endif

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_LATCH  = 2'b01,
        M_SWEEP  = 2'b10,
        M_OFF    = 2'b11
    } mode_e;

    mode_e               mode_q, mode_d, mode_in;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    presc_q, presc_d;
    logic [OUT_W-1:0]    dec_q, dec_d, onehot;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;

    // All state, including the one-cycle wrap pulse, freezes while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= M_OFF;
            idx_q   <= '0;
            presc_q <= '0;
            dec_q   <= DEC_IDLE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (ena) begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        mode_in = mode_e'(mode_i);
        mode_d  = mode_in;
        idx_d   = idx_q;
        presc_d = '0;
        wrap_d  = 1'b0;

        case (mode_in)
            M_DIRECT: idx_d = sel_i;
            M_LATCH: begin
                if (load_i) idx_d = sel_i;
            end
            M_SWEEP: begin
                // Entry reloads the index and restarts the dwell; no step on that edge.
                if (mode_q != M_SWEEP) begin
                    idx_d = sel_i;
                end else if (presc_q == PRESC_LAST) begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = &idx_q;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        onehot = '0;
        onehot[idx_d] = 1'b1;

        if (mode_in == M_OFF) begin
            dec_d   = DEC_IDLE;
            valid_d = 1'b0;
        end else begin
            dec_d   = onehot ^ DEC_IDLE;
            valid_d = 1'b1;
        end
    end

    assign dec_o   = dec_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule
